// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared definitions for the register_file_tri bank: the
//               write-port operation encoding and the default geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Operation applied to slot WAddr when WE is low
    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } rf_op_e;

    localparam int RF_DEF_BITWIDTH = 8;
    localparam int RF_DEF_DEPTH    = 8;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One asynchronous read port of register_file_tri. Selects a
//               slot, returns 0 for addresses beyond Depth, optionally
//               forwards the in-flight write result, and drives a tri-state
//               bus.
// Revision    : 1.0 - initial release
// Config      : RF_BYPASS_EN - adds the write-through forwarding inputs
// Ports       : i_regs     - flattened storage array from the bank
//               i_raddr    - read select
//               i_oe_n     - active-low output enable
//               i_byp_en   - (RF_BYPASS_EN) a write/modify is in flight
//               i_byp_addr - (RF_BYPASS_EN) slot being written
//               i_byp_data - (RF_BYPASS_EN) value that slot will receive
//               o_q        - tri-state data bus, released when i_oe_n=1
// ============================================================================
module rf_read_port
    import rf_pkg::*;
#(
    parameter int BitWidth  = RF_DEF_BITWIDTH,
    parameter int Depth     = RF_DEF_DEPTH,
    parameter int AddrWidth = $clog2(Depth)
)(
    input  logic [Depth-1:0][BitWidth-1:0] i_regs,
    input  logic [AddrWidth-1:0]           i_raddr,
    input  logic                           i_oe_n,
`ifdef RF_BYPASS_EN
    input  logic                           i_byp_en,
    input  logic [AddrWidth-1:0]           i_byp_addr,
    input  logic [BitWidth-1:0]            i_byp_data,
`endif
    output tri   [BitWidth-1:0]            o_q
);

    logic [BitWidth-1:0] w_data;

    // Unmatched addresses (>= Depth) fall through to the zero default
    always_comb begin
        w_data = '0;
        for (int i = 0; i < Depth; i++) begin
            if (i_raddr == AddrWidth'(i)) begin
                w_data = i_regs[i];
            end
        end
`ifdef RF_BYPASS_EN
        if (i_byp_en && (i_byp_addr == i_raddr)) begin
            w_data = i_byp_data;
        end
`endif
    end

    assign o_q = i_oe_n ? {BitWidth{1'bz}} : w_data;

endmodule
`default_nettype wire

// File: rtl/register_file_tri.sv
`default_nettype none
// ============================================================================
// Module      : register_file_tri
// Description : Depth x BitWidth register bank with one synchronous
//               load/inc/dec/clear port, two tri-state read ports and
//               registered Zero/Carry flags from the last modify.
// Revision    : 1.0 - initial release
// Config      : RF_BYPASS_EN - forward the in-flight write result to any
//               enabled read port addressing the written slot
// Ports       : Clk          - clock, rising edge
//               Reset        - asynchronous active-low reset
//               WE           - active-low write/modify enable
//               Op           - OP_LOAD / OP_INC / OP_DEC / OP_CLR
//               WAddr, WD    - target slot and load data
//               RAddrA/B     - read selects
//               OEA/OEB      - active-low output enables
//               QA/QB        - tri-state read buses
//               Zero, Carry  - registered flags of the last modify
// RDelay is a simulation-only delay; this RTL models the updates and
// drivers with zero delay.
// ============================================================================
module register_file_tri
    import rf_pkg::*;
#(
    parameter int BitWidth  = RF_DEF_BITWIDTH,
    parameter int Depth     = RF_DEF_DEPTH,
    parameter int AddrWidth = $clog2(Depth),
    parameter int RDelay    = 1
)(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 WE,
    input  logic [1:0]           Op,
    input  logic [AddrWidth-1:0] WAddr,
    input  logic [BitWidth-1:0]  WD,
    input  logic [AddrWidth-1:0] RAddrA,
    input  logic                 OEA,
    output tri   [BitWidth-1:0]  QA,
    input  logic [AddrWidth-1:0] RAddrB,
    input  logic                 OEB,
    output tri   [BitWidth-1:0]  QB,
    output logic                 Zero,
    output logic                 Carry
);

    // An illegal configuration leaves the bank write-disabled
    localparam bit c_PARAMS_OK = (Depth >= 2) && (RDelay >= 0);

    logic [Depth-1:0][BitWidth-1:0] r_regs;
    logic                           r_zero;
    logic                           r_carry;

    logic                           w_wr_en;
    logic [BitWidth-1:0]            w_cur;
    logic [BitWidth:0]              w_next;   // MSB is carry / borrow

    // Writes to slots beyond Depth are dropped, flags included
    assign w_wr_en = c_PARAMS_OK && !WE && (int'(WAddr) < Depth);

    // Modify ALU, one bit wider than the word so the MSB is the carry
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < Depth; i++) begin
            if (WAddr == AddrWidth'(i)) begin
                w_cur = r_regs[i];
            end
        end
        case (Op)
            OP_LOAD: w_next = {1'b0, WD};
            OP_INC:  w_next = {1'b0, w_cur} + (BitWidth+1)'(1);
            OP_DEC:  w_next = {1'b0, w_cur} - (BitWidth+1)'(1);
            default: w_next = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_regs  <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_wr_en) begin
            for (int i = 0; i < Depth; i++) begin
                if (WAddr == AddrWidth'(i)) begin
                    r_regs[i] <= w_next[BitWidth-1:0];
                end
            end
            r_zero  <= (w_next[BitWidth-1:0] == '0);
            r_carry <= w_next[BitWidth];
        end
    end

    assign Zero  = r_zero;
    assign Carry = r_carry;

`ifdef RF_BYPASS_EN
    // Forwarding is suppressed during reset so enabled ports read 0
    logic w_byp_en;
    assign w_byp_en = Reset && w_wr_en;
`endif

    rf_read_port #(
        .BitWidth  (BitWidth),
        .Depth     (Depth),
        .AddrWidth (AddrWidth)
    ) u_port_a (
        .i_regs     (r_regs),
        .i_raddr    (RAddrA),
        .i_oe_n     (OEA),
`ifdef RF_BYPASS_EN
        .i_byp_en   (w_byp_en),
        .i_byp_addr (WAddr),
        .i_byp_data (w_next[BitWidth-1:0]),
`endif
        .o_q        (QA)
    );

    rf_read_port #(
        .BitWidth  (BitWidth),
        .Depth     (Depth),
        .AddrWidth (AddrWidth)
    ) u_port_b (
        .i_regs     (r_regs),
        .i_raddr    (RAddrB),
        .i_oe_n     (OEB),
`ifdef RF_BYPASS_EN
        .i_byp_en   (w_byp_en),
        .i_byp_addr (WAddr),
        .i_byp_data (w_next[BitWidth-1:0]),
`endif
        .o_q        (QB)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file_tri.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_tri
// Description : Directed, table-driven bench for register_file_tri with
//               hand-written sequences for reset, bus release, read/write
//               collision and asynchronous reset mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_tri;
    import rf_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       WE;
    logic [1:0] Op;
    logic [2:0] WAddr;
    logic [7:0] WD;
    logic [2:0] RAddrA;
    logic       OEA;
    logic [2:0] RAddrB;
    logic       OEB;
    logic       Zero;
    logic       Carry;
    tri   [7:0] QA;
    tri   [7:0] QB;

    // Bench-side bus drivers: while the DUT has released a bus, it must
    // read exactly the value the bench places on it.
    logic r_probe_a;
    logic r_probe_b;
    assign QA = r_probe_a ? 8'h00 : 8'hzz;
    assign QB = r_probe_b ? 8'h00 : 8'hzz;

    int checks;
    int errors;

    register_file_tri dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .WE     (WE),
        .Op     (Op),
        .WAddr  (WAddr),
        .WD     (WD),
        .RAddrA (RAddrA),
        .OEA    (OEA),
        .QA     (QA),
        .RAddrB (RAddrB),
        .OEB    (OEB),
        .QB     (QB),
        .Zero   (Zero),
        .Carry  (Carry)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic       we;
        logic [1:0] op;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] eqa;
        logic [7:0] eqb;
        logic       ez;
        logic       ec;
    } vec_t;

    vec_t vecs [13];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge Clk);
        WE = v.we; Op = v.op; WAddr = v.wa; WD = v.wd;
        RAddrA = v.ra; RAddrB = v.rb;
        @(posedge Clk);
        #1 WE = 1'b1;
        #1;
        chk8($sformatf("vec%0d_qa", idx), QA, v.eqa);
        chk8($sformatf("vec%0d_qb", idx), QB, v.eqb);
        chk1($sformatf("vec%0d_zero", idx), Zero, v.ez);
        chk1($sformatf("vec%0d_carry", idx), Carry, v.ec);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        r_probe_a = 1'b0; r_probe_b = 1'b0;
        WE = 1'b1; Op = OP_LOAD; WAddr = 3'd0; WD = 8'h00;
        RAddrA = 3'd3; RAddrB = 3'd0; OEA = 1'b0; OEB = 1'b0;

        //                we    op       wa    wd     ra    rb    eqa    eqb    z     c
        vecs[0]  = '{1'b0, OP_LOAD, 3'd3, 8'hA5, 3'd3, 3'd0, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, OP_LOAD, 3'd2, 8'hFF, 3'd2, 3'd3, 8'hFF, 8'hA5, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, OP_INC,  3'd2, 8'h00, 3'd2, 3'd3, 8'h00, 8'hA5, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, OP_INC,  3'd2, 8'h00, 3'd2, 3'd3, 8'h01, 8'hA5, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, OP_LOAD, 3'd5, 8'h00, 3'd5, 3'd2, 8'h00, 8'h01, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, OP_DEC,  3'd5, 8'h00, 3'd5, 3'd2, 8'hFF, 8'h01, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, OP_CLR,  3'd5, 8'h77, 3'd5, 3'd2, 8'h00, 8'h01, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, OP_LOAD, 3'd4, 8'h5A, 3'd4, 3'd4, 8'h5A, 8'h5A, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, OP_DEC,  3'd6, 8'h00, 3'd6, 3'd4, 8'hFF, 8'h5A, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, OP_INC,  3'd6, 8'h00, 3'd6, 3'd4, 8'hFF, 8'h5A, 1'b0, 1'b1};
        vecs[10] = '{1'b0, OP_LOAD, 3'd7, 8'h01, 3'd7, 3'd1, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, OP_DEC,  3'd7, 8'h00, 3'd7, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b0, OP_INC,  3'd3, 8'h00, 3'd3, 3'd7, 8'hA6, 8'h00, 1'b0, 1'b0};

        // Reset without a clock edge
        Reset = 1'b1;
        #1 Reset = 1'b0;
        #1;
        chk8("reset_qa", QA, 8'h00);
        chk8("reset_qb", QB, 8'h00);
        chk1("reset_zero", Zero, 1'b0);
        chk1("reset_carry", Carry, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply(i, vecs[i]);
        end

        // Output enables: slot 4 holds 0x5A
        @(negedge Clk);
        RAddrA = 3'd4; RAddrB = 3'd4;
        OEA = 1'b1; OEB = 1'b0; r_probe_a = 1'b1;
        #1;
        chk8("oea_hi_release", QA, 8'h00);
        chk8("oea_hi_qb", QB, 8'h5A);
        r_probe_a = 1'b0; OEA = 1'b0;
        #1;
        chk8("both_en_qa", QA, 8'h5A);
        chk8("both_en_qb", QB, 8'h5A);
        OEB = 1'b1; r_probe_b = 1'b1;
        #1;
        chk8("oeb_hi_release", QB, 8'h00);
        r_probe_b = 1'b0; OEB = 1'b0;

        // Same-cycle write and read of slot 1 (currently 0x00)
        @(negedge Clk);
        WE = 1'b0; Op = OP_LOAD; WAddr = 3'd1; WD = 8'h3C; RAddrA = 3'd1;
        #1;
`ifdef RF_BYPASS_EN
        chk8("collide_before_edge", QA, 8'h3C);
`else
        chk8("collide_before_edge", QA, 8'h00);
`endif
        @(posedge Clk);
        #1;
        chk8("collide_after_edge", QA, 8'h3C);
        WE = 1'b1;

        // Slot 0: 0 -> 0xFF with borrow, to give the flags something to clear
        @(negedge Clk);
        WE = 1'b0; Op = OP_DEC; WAddr = 3'd0; RAddrA = 3'd0;
        @(posedge Clk);
        #1 WE = 1'b1;
        #1;
        chk8("dec0_qa", QA, 8'hFF);
        chk1("dec0_carry", Carry, 1'b1);

        // Asynchronous reset between edges while an increment is pending
        @(negedge Clk);
        WE = 1'b0; Op = OP_INC; WAddr = 3'd0; RAddrA = 3'd0;
        #2 Reset = 1'b0;
        #1;
        chk8("async_rst_qa", QA, 8'h00);
        chk1("async_rst_carry", Carry, 1'b0);
        chk1("async_rst_zero", Zero, 1'b0);
        for (int s = 0; s < 8; s++) begin
            RAddrA = 3'(s);
            #1;
            chk8($sformatf("async_rst_slot%0d", s), QA, 8'h00);
        end
        @(posedge Clk);
        #1;
        RAddrA = 3'd0;
        #1;
        chk8("rst_edge_no_inc", QA, 8'h00);
        chk1("rst_edge_carry", Carry, 1'b0);

        // First edge after release performs the pending increment
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1 WE = 1'b1;
        #1;
        chk8("post_rst_inc", QA, 8'h01);
        chk1("post_rst_zero", Zero, 1'b0);
        chk1("post_rst_carry", Carry, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
